// File: rtl/instr_encoder.sv
// Program loader: packs decoded instruction fields into 49-bit words and streams
// them through a small FIFO into sequential instruction-memory writes.
module instr_encoder #(
  parameter int AW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [1:0]    in_mode,
  input  logic [4:0]    in_src,
  input  logic [4:0]    in_dst,
  input  logic [31:0]   in_lit,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [48:0]   mem_wdata,
  input  logic          mem_ready,
  output logic [AW:0]   count,
  output logic          err_illegal,
  output logic          ovf
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [AW:0] CAP      = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LAST_ACC = {1'b0, {AW{1'b1}}};

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state;
  logic [48:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [AW:0]   acc_cnt;

  logic fifo_full;
  logic fifo_empty;
  logic legal;
  logic accept;
  logic push;
  logic pop;

  // in_ready depends only on registered state, never on mem_ready.
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign in_ready   = (state == LOAD) && !fifo_full && (acc_cnt < CAP);
  assign accept     = in_valid && in_ready;
  assign legal      = (in_op <= 5'h12);
  assign push       = accept && legal;
  assign mem_we     = !fifo_empty;
  assign pop        = mem_we && mem_ready;
  assign mem_wdata  = mem_we ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_op, in_mode, in_src, in_dst, in_lit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // The accept cap bounds writes to 2^AW, so the address saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      count    <= '0;
    end else if (state == IDLE && start) begin
      mem_addr <= '0;
      count    <= '0;
    end else if (pop) begin
      count <= count + (AW+1)'(1);
      if (mem_addr != '1) mem_addr <= mem_addr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      ovf         <= 1'b0;
      acc_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state       <= LOAD;
            busy        <= 1'b1;
            err_illegal <= 1'b0;
            ovf         <= 1'b0;
            acc_cnt     <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (legal) acc_cnt <= acc_cnt + (AW+1)'(1);
            else       err_illegal <= 1'b1;
            if (in_last) begin
              state <= DRAIN;
            end else if (legal && acc_cnt == LAST_ACC) begin
              ovf   <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a field-level reference model queues the
// expected memory writes, and a negedge monitor compares every completed write.
module tb_instr_encoder;

  localparam int AW  = 3;
  localparam int FD  = 4;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = '0;
  logic [1:0]    in_mode = '0;
  logic [4:0]    in_src = '0;
  logic [4:0]    in_dst = '0;
  logic [31:0]   in_lit = '0;
  logic          in_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [48:0]   mem_wdata;
  logic          mem_ready = 1'b0;
  logic [AW:0]   count;
  logic          err_illegal;
  logic          ovf;

  instr_encoder #(.AW(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_mode(in_mode),
    .in_src(in_src), .in_dst(in_dst), .in_lit(in_lit), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .count(count), .err_illegal(err_illegal), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [48:0]   word;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  int   legal_cnt = 0;
  bit   exp_err = 0;
  bit   exp_ovf = 0;
  bit   load_over = 0;
  bit   mr_rand = 0;

  logic        prev_stall = 1'b0;
  logic [48:0] prev_wdata = '0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: legal ops become the next sequential word; the load ends on last or at capacity.
  task automatic model_accept(input logic [4:0] op, input logic [1:0] mode, input logic [4:0] src,
                              input logic [4:0] dst, input logic [31:0] lit, input logic last);
    exp_t e;
    if (op <= 5'd18) begin
      e.addr = AW'(legal_cnt);
      e.word = {op, mode, src, dst, lit};
      exp_q.push_back(e);
      legal_cnt++;
    end else begin
      exp_err = 1;
    end
    if (last) load_over = 1;
    else if (legal_cnt == CAP) begin
      exp_ovf   = 1;
      load_over = 1;
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [1:0] mode, input logic [4:0] src,
                      input logic [4:0] dst, input logic [31:0] lit, input logic last);
    bit acc = 0;
    in_valid = 1'b1; in_op = op; in_mode = mode; in_src = src;
    in_dst = dst; in_lit = lit; in_last = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        model_accept(op, mode, src, dst, lit, last);
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("handshake_within_bound", 64'(acc), 64'd1);
  endtask

  task automatic send_rand(input logic [4:0] op, input logic last);
    send(op, 2'($urandom), 5'($urandom), 5'($urandom), $urandom, last);
  endtask

  task automatic do_start();
    legal_cnt = 0; exp_err = 0; exp_ovf = 0; load_over = 0; done_seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic finish_load(input string tag);
    bit got = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    check({tag, "_done_within_bound"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_count"}, 64'(count), 64'(legal_cnt));
      check({tag, "_err_illegal"}, 64'(err_illegal), 64'(exp_err));
      check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
      check({tag, "_writes_outstanding"}, 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, 64'(done_seen), 64'd1);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
      check({tag, "_err_sticky"}, 64'(err_illegal), 64'(exp_err));
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_err_illegal"}, 64'(err_illegal), 64'd0);
    check({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  always @(posedge clk) begin
    #2;
    if (mr_rand) mem_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: every completed write is popped from the scoreboard; stalled words must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_seen++;
      if (prev_stall) begin
        check("stall_hold_we", 64'(mem_we), 64'd1);
        check("stall_hold_wdata", 64'(mem_wdata), 64'(prev_wdata));
        check("stall_hold_addr", 64'(mem_addr), 64'(prev_addr));
      end
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 64'(mem_addr), 64'h1_0000_0000);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_addr", 64'(mem_addr), 64'(e.addr));
          check("write_data", 64'(mem_wdata), 64'(e.word));
        end
      end
      prev_stall = mem_we && !mem_ready;
      prev_wdata = mem_wdata;
      prev_addr  = mem_addr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [48:0] word0;
    word0 = {5'h01, 2'b01, 5'd2, 5'd3, 32'hDEADBEEF};

    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Basic load
    mem_ready = 1'b1;
    do_start();
    check("basic_busy", 64'(busy), 64'd1);
    send(5'h01, 2'd1, 5'd2, 5'd3, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("basic_latency_we", 64'(mem_we), 64'd1);
    check("basic_word0", 64'(mem_wdata), 64'(word0));
    @(posedge clk); #1;
    send_rand(5'h02, 1'b0);
    send_rand(5'h10, 1'b1);
    finish_load("basic");

    // Backpressure: FIFO fills at 4, words hold, then drain in order
    mem_ready = 1'b0;
    do_start();
    check("bp_err_cleared", 64'(err_illegal), 64'd0);
    for (int i = 0; i < 4; i++) send_rand(5'($urandom_range(0, 18)), 1'b0);
    @(negedge clk);
    check("bp_in_ready_full", 64'(in_ready), 64'd0);
    check("bp_head_word", 64'(mem_wdata), 64'(exp_q[0].word));
    @(posedge clk); #1;
    fork
      begin
        send_rand(5'($urandom_range(0, 18)), 1'b0);
        send_rand(5'($urandom_range(0, 18)), 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1 mem_ready = 1'b1;
      end
    join
    finish_load("backpressure");

    // Illegal op is handshaken but dropped
    do_start();
    send_rand(5'h01, 1'b0);
    send_rand(5'h15, 1'b0);
    send_rand(5'h11, 1'b1);
    finish_load("illegal");

    // Overflow: capacity reached without last
    do_start();
    check("ovf_err_cleared", 64'(err_illegal), 64'd0);
    mr_rand = 1;
    for (int i = 0; i < 10; i++) begin
      if (!load_over) send_rand(5'($urandom_range(0, 18)), 1'b0);
    end
    mr_rand = 0;
    #1 mem_ready = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ovf_in_ready_low", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    finish_load("overflow");

    // Start during DRAIN is ignored
    mem_ready = 1'b0;
    do_start();
    send_rand(5'h03, 1'b0);
    send_rand(5'h04, 1'b1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_ready = 1'b1;
    finish_load("start_busy");

    // Reset mid-load with two words queued
    mem_ready = 1'b0;
    do_start();
    send_rand(5'h05, 1'b0);
    send_rand(5'h06, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postreset_in_ready", 64'(in_ready), 64'd0);
      check("postreset_mem_we", 64'(mem_we), 64'd0);
    end
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    check("restart_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send_rand(5'h07, 1'b1);
    finish_load("after_reset");

    // Randomized loads with gaps, illegal ops and backpressure
    mr_rand = 1;
    for (int l = 0; l < 8; l++) begin
      int n;
      n = $urandom_range(1, 11);
      do_start();
      for (int i = 0; i < n; i++) begin
        logic [4:0] op;
        if (load_over) break;
        op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_rand(op, 1'(i == n - 1));
      end
      finish_load("random");
    end
    mr_rand = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
